// File: rtl/waterfall_scheduler.sv
// Frame RAM arbiter: the LCD scan reads during the visible area, buffered ADC pixels are written
// during blanking into a circular row buffer. Optional macro WF_DECIM_EN averages 2^DECIM_LOG2 samples per pixel.
module waterfall_scheduler #(
  parameter int H_RES        = 320,
  parameter int V_RES        = 240,
  parameter int SAMPLE_WIDTH = 12,
  parameter int FIFO_DEPTH   = 8,
  parameter int DECIM_LOG2   = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    visible,
  input  logic [8:0]              x,
  input  logic [7:0]              y,
  input  logic                    frame_start,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic [16:0]             ram_addr,
  output logic [7:0]              ram_wdata,
  output logic                    ram_we,
  output logic                    overflow,
  output logic [7:0]              top_row
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    OWN_READ,
    OWN_WRITE,
    OWN_IDLE
  } own_e;

  own_e own;

  logic [7:0]       fifo_mem_q [FIFO_DEPTH];
  logic [7:0]       fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       col_q, col_d;
  logic [7:0]       wr_row_q, wr_row_d;
  logic [7:0]       top_row_q, top_row_d;
  logic             overflow_q, overflow_d;

  logic             push_req;
  logic [7:0]       push_data;
  logic             push_ok;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;

  logic [8:0]       disp_sum;
  logic [7:0]       disp_row;
  logic [16:0]      rd_addr;
  logic [16:0]      wr_addr;

`ifdef WF_DECIM_EN
  localparam int ACC_W  = SAMPLE_WIDTH + DECIM_LOG2;
  localparam int DCNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [ACC_W-1:0]  acc_sum;

  // Top 8 bits of (sum >> DECIM_LOG2) are simply the top 8 bits of the full-width sum.
  always_comb begin
    acc_sum   = acc_q + ACC_W'(sample_data);
    push_req  = sample_valid && (dcnt_q == DCNT_W'((1 << DECIM_LOG2) - 1));
    push_data = acc_sum[ACC_W-1 -: 8];
    acc_d     = acc_q;
    dcnt_d    = dcnt_q;
    if (sample_valid) begin
      if (push_req) begin
        acc_d  = '0;
        dcnt_d = '0;
      end else begin
        acc_d  = acc_sum;
        dcnt_d = dcnt_q + DCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q  <= '0;
      dcnt_q <= '0;
    end else begin
      acc_q  <= acc_d;
      dcnt_q <= dcnt_d;
    end
  end
`else
  localparam int unused_decim_log2 = DECIM_LOG2;
  logic [SAMPLE_WIDTH-9:0] unused_sample_lsbs;

  assign unused_sample_lsbs = sample_data[SAMPLE_WIDTH-9:0];

  always_comb begin
    push_req  = sample_valid;
    push_data = sample_data[SAMPLE_WIDTH-1 -: 8];
  end
`endif

  always_comb begin
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    if (visible)         own = OWN_READ;
    else if (fifo_empty) own = OWN_IDLE;
    else                 own = OWN_WRITE;
    pop     = (own == OWN_WRITE);
    push_ok = push_req && (!fifo_full || pop);
  end

  // Display row is offset by top_row and folded back into 0..V_RES-1.
  always_comb begin
    disp_sum = {1'b0, y} + {1'b0, top_row_q};
    if (disp_sum >= 9'(V_RES)) disp_row = 8'(disp_sum - 9'(V_RES));
    else                       disp_row = disp_sum[7:0];
    rd_addr = 17'(x) + 17'(disp_row) * 17'(H_RES);
    wr_addr = 17'(col_q) + 17'(wr_row_q) * 17'(H_RES);
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_wdata = '0;
    ram_addr  = rd_addr;
    case (own)
      OWN_WRITE: begin
        ram_we    = 1'b1;
        ram_wdata = fifo_mem_q[rd_ptr_q];
        ram_addr  = wr_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q | (push_req && !push_ok);
    if (push_ok) begin
      fifo_mem_d[wr_ptr_q] = push_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // frame_start samples the pre-edge wr_row even when a row wrap happens on the same edge.
  always_comb begin
    col_d     = col_q;
    wr_row_d  = wr_row_q;
    top_row_d = top_row_q;
    if (pop) begin
      if (col_q == 9'(H_RES - 1)) begin
        col_d    = '0;
        wr_row_d = (wr_row_q == 8'(V_RES - 1)) ? '0 : wr_row_q + 8'd1;
      end else begin
        col_d = col_q + 9'd1;
      end
    end
    if (frame_start)
      top_row_d = (wr_row_q == 8'(V_RES - 1)) ? '0 : wr_row_q + 8'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      col_q      <= '0;
      wr_row_q   <= '0;
      top_row_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      wr_row_q   <= wr_row_d;
      top_row_q  <= top_row_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
  assign top_row  = top_row_q;

endmodule

// File: tb/tb_waterfall_scheduler.sv
// Directed bench for waterfall_scheduler in its default build (WF_DECIM_EN undefined).
module tb_waterfall_scheduler;

  logic        clk;
  logic        resetn;
  logic        visible;
  logic [8:0]  x;
  logic [7:0]  y;
  logic        frame_start;
  logic        sample_valid;
  logic [11:0] sample_data;
  logic [16:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic        overflow;
  logic [7:0]  top_row;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  waterfall_scheduler #(
    .H_RES(320),
    .V_RES(240),
    .SAMPLE_WIDTH(12),
    .FIFO_DEPTH(8),
    .DECIM_LOG2(2)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .visible(visible),
    .x(x),
    .y(y),
    .frame_start(frame_start),
    .sample_valid(sample_valid),
    .sample_data(sample_data),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we(ram_we),
    .overflow(overflow),
    .top_row(top_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams n samples through an initially empty FIFO in blanking; every write must land at the next ring address.
  task automatic stream(input int n, input int start_addr);
    int exp_addr;
    int bad;
    exp_addr = start_addr;
    bad = 0;
    visible = 1'b0;
    for (int i = 0; i <= n; i++) begin
      sample_valid = (i < n);
      sample_data  = 12'((i & 255) << 4);
      #1;
      if (i > 0) begin
        if (!(ram_we === 1'b1 && ram_addr === 17'(exp_addr) && ram_wdata === 8'((i - 1) & 255)))
          bad++;
        exp_addr = (exp_addr == 76799) ? 0 : exp_addr + 1;
      end
      step();
    end
    sample_valid = 1'b0;
    check("stream_bad_writes", bad, 0);
    #1;
    check("stream_drained_we", ram_we, 0);
  endtask

  initial begin
    resetn = 1'b0; visible = 1'b0; x = '0; y = '0;
    frame_start = 1'b0; sample_valid = 1'b0; sample_data = '0;
    #1;
    check("rst_we", ram_we, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_overflow", overflow, 0);
    check("rst_top_row", top_row, 0);
    check("rst_addr0", ram_addr, 0);
    x = 9'd7; y = 8'd2;
    #1;
    check("rst_addr_read", ram_addr, 647);
    step(); step();
    resetn = 1'b1; x = '0; y = '0;

    // T3: two pushes written on consecutive cycles
    sample_valid = 1'b1; sample_data = 12'hABC;
    step();
    sample_data = 12'h123;
    #1;
    check("t3_we0", ram_we, 1);
    check("t3_addr0", ram_addr, 0);
    check("t3_wdata0", ram_wdata, 8'hAB);
    step();
    sample_valid = 1'b0;
    #1;
    check("t3_we1", ram_we, 1);
    check("t3_addr1", ram_addr, 1);
    check("t3_wdata1", ram_wdata, 8'h12);
    step();
    #1;
    check("t3_idle_we", ram_we, 0);

    // T1: reset with 3 samples pending and a nonzero top_row
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    #1;
    check("t1_top_row_pre", top_row, 1);
    visible = 1'b1;
    sample_valid = 1'b1; sample_data = 12'h700; step();
    sample_data = 12'h710; step();
    sample_data = 12'h720; step();
    sample_valid = 1'b0;
    #1;
    check("t1_visible_we", ram_we, 0);
    visible = 1'b0;
    #1;
    check("t1_pending_we", ram_we, 1);
    check("t1_pending_addr", ram_addr, 2);
    check("t1_pending_wdata", ram_wdata, 8'h70);
    resetn = 1'b0;
    #1;
    check("t1_async_we", ram_we, 0);
    check("t1_async_wdata", ram_wdata, 0);
    check("t1_async_top_row", top_row, 0);
    step(); step();
    resetn = 1'b1;
    #1;
    check("t1_post_we", ram_we, 0);
    check("t1_post_overflow", overflow, 0);
    check("t1_post_top_row", top_row, 0);
    check("t1_post_addr", ram_addr, 0);
    sample_valid = 1'b1; sample_data = 12'h555;
    step();
    sample_valid = 1'b0;
    #1;
    check("t1_first_we", ram_we, 1);
    check("t1_first_addr", ram_addr, 0);
    check("t1_first_wdata", ram_wdata, 8'h55);
    step();
    #1;
    check("t1_first_done", ram_we, 0);

    // T5a: fill to full while visible, then push on the first pop cycle (accepted)
    visible = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample_valid = 1'b1; sample_data = 12'((i + 1) << 4);
      step();
    end
    sample_valid = 1'b0;
    #1;
    check("t5a_full_overflow", overflow, 0);
    check("t5a_full_we", ram_we, 0);
    x = 9'd3; y = 8'd1;
    #1;
    check("t5a_read_addr", ram_addr, 323);
    visible = 1'b0; x = '0; y = '0;
    sample_valid = 1'b1; sample_data = 12'h0F0;
    #1;
    check("t5a_pop_we", ram_we, 1);
    check("t5a_pop_addr", ram_addr, 1);
    check("t5a_pop_wdata", ram_wdata, 8'h01);
    step();
    sample_valid = 1'b0;
    #1;
    check("t5a_full_pop_no_ovf", overflow, 0);
    for (int j = 1; j <= 8; j++) begin
      #1;
      check("t5a_drain_we", ram_we, 1);
      check("t5a_drain_addr", ram_addr, 1 + j);
      check("t5a_drain_wdata", ram_wdata, (j < 8) ? j + 1 : 8'h0F);
      step();
    end
    #1;
    check("t5a_empty_we", ram_we, 0);

    // T5b: 9 pushes while visible drop the last one
    visible = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sample_valid = 1'b1; sample_data = 12'((8'h20 + i) << 4);
      step();
    end
    sample_valid = 1'b0;
    #1;
    check("t5b_overflow", overflow, 1);
    visible = 1'b0;
    for (int j = 0; j < 8; j++) begin
      #1;
      check("t5b_drain_we", ram_we, 1);
      check("t5b_drain_addr", ram_addr, 10 + j);
      check("t5b_drain_wdata", ram_wdata, 8'h20 + j);
      step();
    end
    #1;
    check("t5b_dropped_we", ram_we, 0);
    check("t5b_overflow_sticky", overflow, 1);

    // T6: without decimation each sample becomes one pixel
    sample_valid = 1'b1; sample_data = 12'h100;
    step();
    sample_data = 12'h200;
    #1;
    check("t6_addr0", ram_addr, 18);
    check("t6_wdata0", ram_wdata, 8'h10);
    step();
    sample_data = 12'h300;
    #1;
    check("t6_addr1", ram_addr, 19);
    check("t6_wdata1", ram_wdata, 8'h20);
    step();
    sample_data = 12'h400;
    #1;
    check("t6_addr2", ram_addr, 20);
    check("t6_wdata2", ram_wdata, 8'h30);
    step();
    sample_valid = 1'b0;
    #1;
    check("t6_we3", ram_we, 1);
    check("t6_addr3", ram_addr, 21);
    check("t6_wdata3", ram_wdata, 8'h40);
    step();
    #1;
    check("t6_done_we", ram_we, 0);

    // T2: advance to row 4, scroll, then check the read mapping
    stream(1258, 22);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    #1;
    check("t2_top_row", top_row, 5);
    visible = 1'b1;
    sample_valid = 1'b1; sample_data = 12'hAAA; step();
    sample_data = 12'hBBB; step();
    sample_valid = 1'b0;
    x = 9'd10; y = 8'd236;
    #1;
    check("t2_addr_wrap_row", ram_addr, 330);
    check("t2_we_visible", ram_we, 0);
    x = 9'd0; y = 8'd0;
    #1;
    check("t2_addr_top", ram_addr, 1600);
    x = 9'd319; y = 8'd234;
    #1;
    check("t2_addr_max", ram_addr, 76799);
    x = 9'd4; y = 8'd235;
    #1;
    check("t2_addr_fold", ram_addr, 4);
    visible = 1'b0; x = '0; y = '0;
    #1;
    check("t2_w0_addr", ram_addr, 1280);
    check("t2_w0_wdata", ram_wdata, 8'hAA);
    step();
    #1;
    check("t2_w1_addr", ram_addr, 1281);
    check("t2_w1_wdata", ram_wdata, 8'hBB);
    step();
    #1;
    check("t2_done_we", ram_we, 0);

    // T4: fill the ring to the last pixel; frame_start on the wrapping edge uses pre-edge wr_row
    stream(75198, 1282);
    stream(319, 76480);
    sample_valid = 1'b1; sample_data = 12'h3C0;
    step();
    sample_valid = 1'b0; frame_start = 1'b1;
    #1;
    check("t4_last_addr", ram_addr, 76799);
    check("t4_last_wdata", ram_wdata, 8'h3C);
    step();
    frame_start = 1'b0;
    #1;
    check("t4_same_edge_top_row", top_row, 0);
    check("t4_wrap_we", ram_we, 0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    #1;
    check("t4_top_row_after_wrap", top_row, 1);
    sample_valid = 1'b1; sample_data = 12'h5A0;
    step();
    sample_valid = 1'b0;
    #1;
    check("t4_wrap_addr", ram_addr, 0);
    check("t4_wrap_wdata", ram_wdata, 8'h5A);
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
